// File: rtl/rv_instr_gen.sv
// ----------------------------------------------------------------------------
// rv_instr_gen
//
// Self-stimulus instruction source. A 32-bit LFSR is turned into encoded
// RV32I words (OP, OP-IMM, LUI). The words are buffered in a small FIFO and
// delivered over a valid/ready stream. Each run issues a programmed number of
// words and keeps a handshake count and an XOR signature of the delivered
// words. The LFSR is loaded with SEED only on reset, so successive runs
// continue the same sequence.
//
// Optional feature macro: RVGEN_LEGAL_FUNCT7_EN
//   defined   : the funct7 / imm[11:5] field is forced to a legal RV32I value
//   undefined : the raw LFSR bits are used unchanged
//
// Parameters
//   SEED   LFSR value loaded on reset
//   DEPTH  output FIFO entries (power of two, >= 2)
//   CNT_W  width of the instruction count and counters
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset
//   start         in   begin a run (sampled only in IDLE)
//   num_instr     in   instructions to issue in the run (sampled with start)
//   instr_valid   out  FIFO head is valid
//   instr_ready   in   consumer accepts the head
//   instr         out  encoded instruction at the FIFO head (0 when empty)
//   busy          out  high while a run is generating or draining
//   done          out  one-cycle pulse at the end of a run
//   issued_count  out  handshakes completed in the current run
//   instr_xor     out  XOR of all words handshaken in the current run
// ----------------------------------------------------------------------------
module rv_instr_gen #(
    parameter logic [31:0] SEED  = 32'hDEADC0DE,
    parameter int          DEPTH = 4,
    parameter int          CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_instr,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] issued_count,
    output logic [31:0]      instr_xor
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      lfsr_q, lfsr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [CNT_W-1:0] gen_q, gen_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [31:0]      xor_q, xor_d;
    logic [31:0]      mem_q [DEPTH];

    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic [31:0]      head;
    logic [31:0]      gen_word;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    // hi carries lfsr[31:7]; sel carries lfsr[1:0]. Inside hi:
    // hi[24:18] = lfsr[31:25], hi[23] = lfsr[30], hi[7:5] = lfsr[14:12].
    function automatic logic [31:0] encode(input logic [24:0] hi,
                                           input logic [1:0]  sel);
        logic [6:0] opc;
        logic [6:0] upper;
`ifdef RVGEN_LEGAL_FUNCT7_EN
        logic [2:0] f3;
`endif
        case (sel)
            2'd1:    opc = OPC_OPIMM;
            2'd2:    opc = OPC_LUI;
            default: opc = OPC_OP;
        endcase
        upper = hi[24:18];
`ifdef RVGEN_LEGAL_FUNCT7_EN
        f3 = hi[7:5];
        if (opc == OPC_OP) begin
            // ADD/SUB and SRL/SRA are the only OP forms with a non-zero funct7
            upper = (f3 == 3'd0 || f3 == 3'd5) ? {1'b0, hi[23], 5'b0} : 7'b0;
        end else if (opc == OPC_OPIMM) begin
            // SLLI must be zero-extended; SRLI/SRAI pick bit 30 only
            if (f3 == 3'd1) begin
                upper = 7'b0;
            end else if (f3 == 3'd5) begin
                upper = {1'b0, hi[23], 5'b0};
            end
        end
`endif
        return {upper, hi[17:0], opc};
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign head     = mem_q[rd_ptr_q];
    assign pop      = !empty && instr_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge
    assign push     = (state_q == S_RUN) && (!full || pop);
    assign gen_word = encode(lfsr_q[31:7], lfsr_q[1:0]);

    assign instr_valid  = !empty;
    assign instr        = empty ? 32'd0 : head;
    assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done         = (state_q == S_DONE);
    assign issued_count = issued_q;
    assign instr_xor    = xor_q;

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        gen_d    = gen_q;
        target_d = target_q;
        issued_d = issued_q;
        xor_d    = xor_q;

        if (push) begin
            lfsr_d   = lfsr_step(lfsr_q);
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            issued_d = issued_q + CNT_W'(1);
            xor_d    = xor_q ^ head;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    target_d = num_instr;
                    gen_d    = '0;
                    issued_d = '0;
                    xor_d    = '0;
                    state_d  = (num_instr == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (push) begin
                    gen_d = gen_q + CNT_W'(1);
                    if (gen_q + CNT_W'(1) == target_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Leave as soon as the last pop empties the FIFO so done
                // follows that edge directly
                if (empty || (count_q == (AW+1)'(1) && pop)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lfsr_q   <= SEED;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            gen_q    <= '0;
            target_q <= '0;
            issued_q <= '0;
            xor_q    <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            gen_q    <= gen_d;
            target_q <= target_d;
            issued_q <= issued_d;
            xor_q    <= xor_d;
        end
    end

    // FIFO storage carries data only; occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= gen_word;
        end
    end

endmodule

// File: tb/tb_rv_instr_gen.sv
module tb_rv_instr_gen;

    localparam logic [31:0] SEED  = 32'hDEADC0DE;
    localparam int          DEPTH = 4;
    localparam int          CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_instr;
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instr;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] issued_count;
    logic [31:0]      instr_xor;

    rv_instr_gen #(.SEED(SEED), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_instr    (num_instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .busy         (busy),
        .done         (done),
        .issued_count (issued_count),
        .instr_xor    (instr_xor)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          do_rst;
        int          num;
        int          mode;      // 0 ready high, 1 ready low for 'hold' cycles, 2 random
        int          hold;
        int          poke;      // cycle at which a stray start is driven (-1 none)
        logic [31:0] first;
        bit          chk_first;
        logic [31:0] xr;
        bit          chk_xor;
    } vec_t;

    vec_t        tbl [7];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] m_lfsr;
    logic [31:0] m_xor;
    int          m_k;
    logic [31:0] lit_w [3];

    function automatic logic [31:0] m_next(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    function automatic logic [31:0] m_encode(input logic [31:0] l);
        logic [31:0] w;
        logic [6:0]  opc;
        case (l[1:0])
            2'd1:    opc = 7'b0010011;
            2'd2:    opc = 7'b0110111;
            default: opc = 7'b0110011;
        endcase
        w = {l[31:7], opc};
`ifdef RVGEN_LEGAL_FUNCT7_EN
        if (opc == 7'b0110011) begin
            if (l[14:12] == 3'd0 || l[14:12] == 3'd5) w[31:25] = {1'b0, l[30], 5'b0};
            else w[31:25] = 7'd0;
        end else if (opc == 7'b0010011 && l[14:12] == 3'd1) begin
            w[31:25] = 7'd0;
        end else if (opc == 7'b0010011 && l[14:12] == 3'd5) begin
            w[31:25] = {1'b0, l[30], 5'b0};
        end
`endif
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        $display("FAIL %s: cycle budget expired", name);
    endtask

`ifdef RVGEN_LEGAL_FUNCT7_EN
    task automatic chk_legal(input logic [31:0] w);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = w[31:25];
        f3 = w[14:12];
        if (w[6:0] == 7'b0110011) begin
            chk("legal_op_f7", 32'(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))), 32'd1);
        end else if (w[6:0] == 7'b0010011 && f3 == 3'd1) begin
            chk("legal_slli", 32'(f7), 32'd0);
        end else if (w[6:0] == 7'b0010011 && f3 == 3'd5) begin
            chk("legal_srxi", 32'(f7 == 7'h00 || f7 == 7'h20), 32'd1);
        end
    endtask
`endif

    task automatic do_reset();
        rst         = 1'b1;
        start       = 1'b0;
        instr_ready = 1'b0;
        num_instr   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        m_lfsr = SEED;
        m_k    = 0;
        m_xor  = 32'd0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_valid",  32'(instr_valid),  32'd0);
        chk("rst_instr",  instr,             32'd0);
        chk("rst_busy",   32'(busy),         32'd0);
        chk("rst_done",   32'(done),         32'd0);
        chk("rst_issued", 32'(issued_count), 32'd0);
        chk("rst_xor",    instr_xor,         32'd0);
    endtask

    task automatic run(input vec_t v);
        int          got;
        int          last_hs;
        int          bubbles;
        int          limit;
        bit          seen_v;
        bit          holding;
        bit          finished;
        bit          rdy;
        logic [31:0] held;
        logic [31:0] w;
        got = 0; last_hs = -10; bubbles = 0; seen_v = 0; holding = 0; finished = 0;
        held = 32'd0;
        num_instr   = CNT_W'(v.num);
        start       = 1'b1;
        instr_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        m_xor = 32'd0;
        if (v.num == 0) begin
            chk("zero_done",   32'(done),         32'd1);
            chk("zero_valid",  32'(instr_valid),  32'd0);
            chk("zero_busy",   32'(busy),         32'd0);
            chk("zero_xor",    instr_xor,         32'd0);
            chk("zero_issued", 32'(issued_count), 32'd0);
            @(negedge clk);
            chk("zero_done_pulse", 32'(done),        32'd0);
            chk("zero_valid2",     32'(instr_valid), 32'd0);
            return;
        end
        chk("start_busy",   32'(busy),         32'd1);
        chk("start_valid",  32'(instr_valid),  32'd0);
        chk("start_issued", 32'(issued_count), 32'd0);
        chk("start_xor",    instr_xor,         32'd0);
        limit = 4 * v.num + 64;
        for (int cyc = 0; cyc < limit; cyc++) begin
            if (holding) begin
                chk("hold_stable", instr, held);
                holding = 0;
            end
            if (done) begin
                finished = 1;
                chk("done_latency", 32'(cyc - last_hs), 32'd1);
                break;
            end
            if (cyc == v.poke) begin
                start     = 1'b1;
                num_instr = CNT_W'(3);
            end else begin
                start = 1'b0;
            end
            case (v.mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc >= v.hold);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            instr_ready = rdy;
            if (instr_valid) begin
                seen_v = 1;
                if (rdy) begin
                    w = m_encode(m_lfsr);
                    chk("word", instr, w);
                    if (m_k < 3) chk("word_lit", instr, lit_w[m_k]);
                    if (got == 0 && v.chk_first) chk("first_word", instr, v.first);
`ifdef RVGEN_LEGAL_FUNCT7_EN
                    chk_legal(instr);
`endif
                    m_xor   = m_xor ^ w;
                    m_lfsr  = m_next(m_lfsr);
                    m_k++;
                    got++;
                    last_hs = cyc;
                end else begin
                    holding = 1;
                    held    = instr;
                end
            end else if (seen_v && got < v.num) begin
                bubbles++;
            end
            @(negedge clk);
        end
        start       = 1'b0;
        instr_ready = 1'b0;
        if (!finished) begin
            timeout_fail("run_done");
        end else begin
            chk("end_issued", 32'(issued_count), 32'(v.num));
            chk("end_xor",    instr_xor,         m_xor);
            if (v.chk_xor) chk("end_xor_lit", instr_xor, v.xr);
            chk("end_busy",    32'(busy),        32'd0);
            chk("end_valid",   32'(instr_valid), 32'd0);
            chk("end_bubbles", 32'(bubbles),     32'd0);
            @(negedge clk);
            chk("done_pulse", 32'(done), 32'd0);
            chk("idle_busy",  32'(busy), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        lit_w[0] = 32'hDEADC0B7;
        lit_w[1] = 32'hBD5B8193;
        lit_w[2] = 32'h7AB70337;

        tbl[0] = '{1, 2,    0, 0,  -1, 32'hDEADC0B7, 1, 32'h63F64124, 1};
`ifdef RVGEN_LEGAL_FUNCT7_EN
        tbl[1] = '{0, 2,    0, 0,  -1, 32'h7AB70337, 1, 32'h3BD90584, 1};
`else
        tbl[1] = '{0, 2,    0, 0,  -1, 32'h7AB70337, 1, 32'h8FD90584, 1};
`endif
        tbl[2] = '{1, 8,    1, 10, -1, 32'hDEADC0B7, 1, 32'd0, 0};
        tbl[3] = '{0, 0,    0, 0,  -1, 32'd0,        0, 32'd0, 0};
        tbl[4] = '{0, 6,    0, 0,   3, 32'd0,        0, 32'd0, 0};
        tbl[5] = '{1, 40,   2, 0,  -1, 32'hDEADC0B7, 1, 32'd0, 0};
        tbl[6] = '{0, 1000, 2, 0,  -1, 32'd0,        0, 32'd0, 0};

        do_reset();
        chk_reset_outputs();

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].do_rst) do_reset();
            run(tbl[i]);
        end

        // Reset in the middle of a run discards everything
        do_reset();
        num_instr = CNT_W'(10);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got   = 0;
        for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
            instr_ready = 1'b1;
            if (instr_valid) begin
                chk("midrun_word", instr, m_encode(m_lfsr));
                m_lfsr = m_next(m_lfsr);
                got++;
            end
            @(negedge clk);
        end
        if (got < 3) timeout_fail("midrun_handshakes");
        rst         = 1'b1;
        instr_ready = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        rst    = 1'b0;
        m_lfsr = SEED;
        m_k    = 0;
        run('{0, 1, 0, 0, -1, 32'hDEADC0B7, 1, 32'hDEADC0B7, 1});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
